// File: rtl/iiitb_rc_if.sv
// Bundles the seed, state and status signals of one iiitb_rc ring counter.
// Master drives the seed and observes the counter; slave is the counter side.
interface iiitb_rc_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             wrap;

    modport master (output init, input out, valid, wrap);
    modport slave  (input init, output out, valid, wrap);
endinterface

// File: rtl/iiitb_rc.sv
// Ring / Johnson counter that rotates a seed one bit per clock; optional IIITB_RC_SELFCORRECT_EN recovery.
// Latency: out registered, changes one clock after each edge; valid/wrap are combinational from out.
// Backpressure: none, the counter steps on every rising edge while reset is low.
module iiitb_rc #(
    parameter int WIDTH   = 4,
    parameter int DIR     = 0,
    parameter int JOHNSON = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] init,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             wrap
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] inv_q;
    logic             onehot;
    logic             johnson_ok;
    logic             ins_bit;

    assign inv_q      = ~out_q;
    assign onehot     = (out_q != '0) && ((out_q & (out_q - WIDTH'(1))) == '0);
    // 0..01..1 has no carry overlap with itself+1; 1..10..0 is the same test on the inverse.
    assign johnson_ok = ((out_q & (out_q + WIDTH'(1))) == '0) ||
                        ((inv_q & (inv_q + WIDTH'(1))) == '0);

    assign valid = (JOHNSON != 0) ? johnson_ok : onehot;
    assign wrap  = (DIR == 0) ? out_q[WIDTH-1] : out_q[0];
    assign out   = out_q;

    always_comb begin
        ins_bit = (JOHNSON != 0) ? ~wrap : wrap;
        if (DIR == 0) begin
            out_d = {out_q[WIDTH-2:0], ins_bit};
        end else begin
            out_d = {ins_bit, out_q[WIDTH-1:1]};
        end
`ifdef IIITB_RC_SELFCORRECT_EN
        if (!valid) begin
            out_d = (JOHNSON != 0) ? '0 : WIDTH'(1);
        end
`endif
    end

    // Per-bit async set/clear so that seed changes during reset reach out without a clock.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bit_set;
        logic bit_clr;
        logic bit_q;

        assign bit_set  = reset & init[i];
        assign bit_clr  = reset & ~init[i];
        assign out_q[i] = bit_q;

        always_ff @(posedge clk or posedge bit_set or posedge bit_clr) begin
            if (bit_clr) begin
                bit_q <= 1'b0;
            end else if (bit_set) begin
                bit_q <= 1'b1;
            end else begin
                bit_q <= out_d[i];
            end
        end
    end

endmodule

// File: tb/tb_iiitb_rc.sv
// Directed check of ring-left, ring-right, Johnson and odd-seed counters sharing one clock/reset.
module tb_iiitb_rc;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    iiitb_rc_if #(.WIDTH(4)) if_a ();
    iiitb_rc_if #(.WIDTH(4)) if_b ();
    iiitb_rc_if #(.WIDTH(4)) if_c ();
    iiitb_rc_if #(.WIDTH(4)) if_d ();
    iiitb_rc_if #(.WIDTH(4)) if_e ();
    iiitb_rc_if #(.WIDTH(4)) if_f ();

    iiitb_rc u_a (.clk(clk), .reset(rst), .init(if_a.init), .out(if_a.out), .valid(if_a.valid), .wrap(if_a.wrap));
    iiitb_rc #(.WIDTH(4), .DIR(1), .JOHNSON(0)) u_b (.clk(clk), .reset(rst), .init(if_b.init), .out(if_b.out), .valid(if_b.valid), .wrap(if_b.wrap));
    iiitb_rc #(.WIDTH(4), .DIR(0), .JOHNSON(1)) u_c (.clk(clk), .reset(rst), .init(if_c.init), .out(if_c.out), .valid(if_c.valid), .wrap(if_c.wrap));
    iiitb_rc u_d (.clk(clk), .reset(rst), .init(if_d.init), .out(if_d.out), .valid(if_d.valid), .wrap(if_d.wrap));
    iiitb_rc u_e (.clk(clk), .reset(rst), .init(if_e.init), .out(if_e.out), .valid(if_e.valid), .wrap(if_e.wrap));
    iiitb_rc u_f (.clk(clk), .reset(rst), .init(if_f.init), .out(if_f.out), .valid(if_f.valid), .wrap(if_f.wrap));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected state after each post-reset edge, indexed (edge-1) mod period.
    logic [3:0] seq_a  [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] wrap_a [4] = '{4'd0, 4'd1, 4'd0, 4'd0};
    logic [3:0] seq_b  [4] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
    logic [3:0] wrap_b [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic [3:0] seq_c  [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000, 4'b0000};
`ifdef IIITB_RC_SELFCORRECT_EN
    logic [3:0] seq_d  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] vld_d      = 4'd1;
`else
    logic [3:0] seq_d  [4] = '{4'b1100, 4'b1001, 4'b0011, 4'b0110};
    logic [3:0] vld_d      = 4'd0;
`endif

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        if_a.init = 4'b0010;
        if_b.init = 4'b0010;
        if_c.init = 4'b0000;
        if_d.init = 4'b0110;
        if_e.init = 4'b0000;
        if_f.init = 4'b1111;

        // Reset held through the first rising edge.
        @(negedge clk);
        chk("rst_a_out",   if_a.out, 4'b0010);
        chk("rst_a_valid", {3'b0, if_a.valid}, 4'd1);
        chk("rst_a_wrap",  {3'b0, if_a.wrap}, 4'd0);
        chk("rst_b_out",   if_b.out, 4'b0010);
        chk("rst_c_out",   if_c.out, 4'b0000);
        chk("rst_c_valid", {3'b0, if_c.valid}, 4'd1);
        chk("rst_d_out",   if_d.out, 4'b0110);
        chk("rst_d_valid", {3'b0, if_d.valid}, 4'd0);
        chk("rst_e_out",   if_e.out, 4'b0000);
        chk("rst_f_out",   if_f.out, 4'b1111);
        rst = 1'b0;

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk("a_out",   if_a.out, seq_a[k % 4]);
            chk("a_wrap",  {3'b0, if_a.wrap}, wrap_a[k % 4]);
            chk("a_valid", {3'b0, if_a.valid}, 4'd1);
            chk("b_out",   if_b.out, seq_b[k % 4]);
            chk("b_wrap",  {3'b0, if_b.wrap}, wrap_b[k % 4]);
            chk("c_out",   if_c.out, seq_c[k % 8]);
            chk("c_valid", {3'b0, if_c.valid}, 4'd1);
            chk("d_out",   if_d.out, seq_d[k % 4]);
            if (k > 0 || vld_d == 4'd0) begin
                chk("d_valid", {3'b0, if_d.valid}, vld_d);
            end
            chk("e_out",   if_e.out, 4'b0000);
            chk("e_valid", {3'b0, if_e.valid}, 4'd0);
            chk("f_out",   if_f.out, 4'b1111);
            chk("f_valid", {3'b0, if_f.valid}, 4'd0);
        end
        chk("a_after17", if_a.out, 4'b0100);

        @(negedge clk);
        chk("a_pre_rst_out",  if_a.out, 4'b1000);
        chk("a_pre_rst_wrap", {3'b0, if_a.wrap}, 4'd1);

        // Reset raised between edges must load the seed without a clock.
        if_a.init = 4'b0001;
        rst       = 1'b1;
        #1;
        chk("a_async_load", if_a.out, 4'b0001);
        repeat (2) @(negedge clk);
        chk("a_rst_hold", if_a.out, 4'b0001);
        if_a.init = 4'b1000;
        #1;
        chk("a_init_follow", if_a.out, 4'b1000);
        chk("a_init_wrap",   {3'b0, if_a.wrap}, 4'd1);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("a_post_rst", if_a.out, 4'b0001);
        chk("c_post_rst", if_c.out, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
